// File: rtl/pmem_sync_if.sv
// pmem_sync port bundle: one read port, one byte-masked write port,
// plus clear-engine status and error pulse.
interface pmem_sync_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  busy;
  logic                  err;

  modport master (
    output rd_en, rd_addr,
    output wr_en, wr_addr, wr_data, wr_be,
    input  rd_data, rd_valid, busy, err
  );

  modport slave (
    input  rd_en, rd_addr,
    input  wr_en, wr_addr, wr_data, wr_be,
    output rd_data, rd_valid, busy, err
  );
endinterface

// File: rtl/pmem_sync.sv
// Synchronous 1R1W memory: registered read, byte-lane writes,
// write-first forwarding, range error and post-reset clear engine.
module pmem_sync #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int DEPTH          = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  pmem_sync_if.slave bus
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic              rd_valid_q;
  logic              err_q;

  logic              rd_oor;
  logic              wr_oor;
  logic              ready;
  logic              wr_ok;
  logic              hit;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_fwd;
  logic              err_d;

  assign ready  = (state == READY);
  assign rd_oor = {1'b0, bus.rd_addr} >= LIMIT;
  assign wr_oor = {1'b0, bus.wr_addr} >= LIMIT;
  assign wr_ok  = ready && bus.wr_en && !wr_oor;
  assign hit    = wr_ok && (bus.wr_addr == bus.rd_addr);

  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++)
      mask[8*i +: 8] = {8{bus.wr_be[i]}};
  end

  // Write-first: enabled lanes of a same-address write bypass the array
  always_comb begin
    rd_word = rd_oor ? '0 : mem[bus.rd_addr];
    rd_fwd  = rd_word;
    if (hit)
      rd_fwd = (rd_word & ~mask) | (bus.wr_data & mask);
  end

  always_comb begin
    err_d = 1'b0;
    if (!ready)
      err_d = bus.rd_en || bus.wr_en;
    else
      err_d = (bus.rd_en && rd_oor) || (bus.wr_en && wr_oor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_ptr    <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q      <= err_d;
      rd_valid_q <= ready && bus.rd_en;
      if (ready && bus.rd_en)
        rd_q <= rd_fwd;
      if (state == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (clr_ptr == LAST)
          state <= READY;
      end
    end
  end

  // Array has no reset; the clear engine zeroes it instead
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < NB; i++)
          if (bus.wr_be[i])
            mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  assign bus.rd_data  = rd_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state == CLEAR);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_pmem_sync.sv
// Bench for pmem_sync: default instance plus a DEPTH=20,
// no-clear instance, checked against an array reference model.
module tb_pmem_sync;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D0 = 32;
  localparam int D1 = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmem_sync_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  pmem_sync_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

  pmem_sync #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(D0), .CLEAR_ON_RESET(1'b1)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  pmem_sync #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(D1), .CLEAR_ON_RESET(1'b0)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m0 [D0];
  logic [31:0] m1 [D1];
  logic [31:0] exp0;
  logic [31:0] exp1;

  function automatic logic [31:0] merge(
    input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    b0.rd_en = 0; b0.rd_addr = '0; b0.wr_en = 0;
    b0.wr_addr = '0; b0.wr_data = '0; b0.wr_be = '0;
    b1.rd_en = 0; b1.rd_addr = '0; b1.wr_en = 0;
    b1.wr_addr = '0; b1.wr_data = '0; b1.wr_be = '0;
  endtask

  task automatic test_reset;
    int cnt;
    idle_all();
    rst_n = 0;
    repeat (3) tick();
    n_chk++;
    if (b0.busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy got %b want 1", b0.busy);
    end
    n_chk++;
    if (b0.rd_valid !== 1'b0 || b0.err !== 1'b0 || b0.rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outs got v=%b e=%b d=%h want 0/0/0",
               b0.rd_valid, b0.err, b0.rd_data);
    end
    n_chk++;
    if (b1.busy !== 1'b0) begin
      n_fail++; $display("FAIL noclr_busy got %b want 0", b1.busy);
    end
    rst_n = 1;
    cnt = 0;
    while (cnt < 100) begin
      if (cnt == 2) begin
        b0.wr_en = 1; b0.wr_addr = 5'd3;
        b0.wr_data = 32'hFFFF_FFFF; b0.wr_be = 4'hF;
      end
      tick();
      cnt++;
      b0.wr_en = 0;
      if (cnt == 3) begin
        n_chk++;
        if (b0.err !== 1'b1) begin
          n_fail++; $display("FAIL busy_reject_err got %b want 1", b0.err);
        end
      end
      if (cnt == 4) begin
        n_chk++;
        if (b0.err !== 1'b0) begin
          n_fail++; $display("FAIL busy_err_pulse got %b want 0", b0.err);
        end
      end
      if (b0.busy !== 1'b1) break;
    end
    n_chk++;
    if (cnt != D0) begin
      n_fail++; $display("FAIL clear_edges got %0d want %0d", cnt, D0);
    end
    for (int a = 0; a < D0; a++) m0[a] = '0;
  endtask

  task automatic test_clear_readback;
    for (int a = 0; a < D0; a++) begin
      b0.rd_en = 1; b0.rd_addr = 5'(a);
      tick();
      n_chk++;
      if (b0.rd_valid !== 1'b1 || b0.rd_data !== m0[a]) begin
        n_fail++;
        $display("FAIL clear_read[%0d] got v=%b d=%h want 1 %h",
                 a, b0.rd_valid, b0.rd_data, m0[a]);
      end
    end
    b0.rd_en = 0;
    tick();
    n_chk++;
    if (b0.rd_valid !== 1'b0 || b0.rd_data !== m0[D0-1]) begin
      n_fail++;
      $display("FAIL idle_hold got v=%b d=%h want 0 %h",
               b0.rd_valid, b0.rd_data, m0[D0-1]);
    end
  endtask

  task automatic test_byte_enable;
    b0.wr_en = 1; b0.wr_addr = 5'd4;
    b0.wr_data = 32'hDEAD_BEEF; b0.wr_be = 4'hF;
    tick();
    b0.wr_data = 32'h1122_3344; b0.wr_be = 4'b0101;
    tick();
    b0.wr_en = 0; b0.rd_en = 1; b0.rd_addr = 5'd4;
    tick();
    b0.rd_en = 0;
    n_chk++;
    if (b0.rd_data !== 32'hDE22_BE44 || b0.rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_enable got %h v=%b want DE22BE44 1",
               b0.rd_data, b0.rd_valid);
    end
    m0[4] = 32'hDE22_BE44;
  endtask

  task automatic test_forwarding;
    b0.wr_en = 1; b0.wr_addr = 5'd7;
    b0.wr_data = 32'hAAAA_AAAA; b0.wr_be = 4'hF;
    tick();
    b0.rd_en = 1; b0.rd_addr = 5'd7;
    b0.wr_data = 32'h5555_5555; b0.wr_be = 4'b0011;
    tick();
    b0.wr_en = 0;
    n_chk++;
    if (b0.rd_data !== 32'hAAAA_5555) begin
      n_fail++; $display("FAIL fwd_same_edge got %h want AAAA5555", b0.rd_data);
    end
    tick();
    b0.rd_en = 0;
    n_chk++;
    if (b0.rd_data !== 32'hAAAA_5555) begin
      n_fail++; $display("FAIL fwd_committed got %h want AAAA5555", b0.rd_data);
    end
    m0[7] = 32'hAAAA_5555;
    exp0 = 32'hAAAA_5555;
  endtask

  task automatic test_random_d0;
    logic ev;
    logic [4:0] ra, wa;
    for (int n = 0; n < 300; n++) begin
      b0.rd_en = 1'($urandom_range(0, 1));
      b0.wr_en = 1'($urandom_range(0, 1));
      ra = 5'($urandom_range(0, D0 - 1));
      wa = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, D0 - 1));
      b0.rd_addr = ra; b0.wr_addr = wa;
      b0.wr_data = $urandom; b0.wr_be = 4'($urandom_range(0, 15));
      ev = b0.rd_en;
      if (b0.rd_en) begin
        exp0 = m0[ra];
        if (b0.wr_en && wa == ra) exp0 = merge(exp0, b0.wr_data, b0.wr_be);
      end
      if (b0.wr_en) m0[wa] = merge(m0[wa], b0.wr_data, b0.wr_be);
      tick();
      n_chk++;
      if (b0.rd_valid !== ev || b0.rd_data !== exp0 || b0.err !== 1'b0) begin
        n_fail++;
        $display("FAIL rand0[%0d] got v=%b d=%h e=%b want %b %h 0",
                 n, b0.rd_valid, b0.rd_data, b0.err, ev, exp0);
      end
    end
    idle_all();
    tick();
  endtask

  task automatic test_fill_d1;
    for (int a = 0; a < D1; a++) begin
      b1.wr_en = 1; b1.wr_addr = 5'(a);
      b1.wr_data = $urandom; b1.wr_be = 4'hF;
      m1[a] = b1.wr_data;
      tick();
    end
    b1.wr_en = 0;
    exp1 = b1.rd_data;
  endtask

  task automatic test_out_of_range;
    logic ev, ee;
    logic [4:0] ra, wa;
    b1.wr_en = 1; b1.wr_addr = 5'd25;
    b1.wr_data = 32'h1234_5678; b1.wr_be = 4'hF;
    tick();
    b1.wr_en = 0;
    n_chk++;
    if (b1.err !== 1'b1) begin
      n_fail++; $display("FAIL oor_wr_err got %b want 1", b1.err);
    end
    tick();
    n_chk++;
    if (b1.err !== 1'b0) begin
      n_fail++; $display("FAIL oor_wr_pulse got %b want 0", b1.err);
    end
    b1.rd_en = 1; b1.rd_addr = 5'd25;
    tick();
    b1.rd_en = 0;
    n_chk++;
    if (b1.rd_data !== 32'h0 || b1.rd_valid !== 1'b1 || b1.err !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_rd got d=%h v=%b e=%b want 0 1 1",
               b1.rd_data, b1.rd_valid, b1.err);
    end
    tick();
    n_chk++;
    if (b1.err !== 1'b0 || b1.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_rd_pulse got e=%b v=%b want 0 0", b1.err, b1.rd_valid);
    end
    b1.rd_en = 1; b1.rd_addr = 5'd25;
    b1.wr_en = 1; b1.wr_addr = 5'd30; b1.wr_be = 4'hF;
    tick();
    b1.rd_en = 0; b1.wr_en = 0;
    tick();
    n_chk++;
    if (b1.err !== 1'b0) begin
      n_fail++; $display("FAIL oor_dual_single got %b want 0", b1.err);
    end
    exp1 = 32'h0;
    for (int n = 0; n < 300; n++) begin
      b1.rd_en = 1'($urandom_range(0, 1));
      b1.wr_en = 1'($urandom_range(0, 1));
      ra = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      b1.rd_addr = ra; b1.wr_addr = wa;
      b1.wr_data = $urandom; b1.wr_be = 4'($urandom_range(0, 15));
      ev = b1.rd_en;
      ee = (b1.rd_en && ra >= D1) || (b1.wr_en && wa >= D1);
      if (b1.rd_en) begin
        exp1 = (ra >= D1) ? 32'h0 : m1[ra];
        if (b1.wr_en && wa == ra && wa < D1)
          exp1 = merge(exp1, b1.wr_data, b1.wr_be);
      end
      if (b1.wr_en && wa < D1) m1[wa] = merge(m1[wa], b1.wr_data, b1.wr_be);
      tick();
      n_chk++;
      if (b1.rd_valid !== ev || b1.rd_data !== exp1 || b1.err !== ee) begin
        n_fail++;
        $display("FAIL rand1[%0d] got v=%b d=%h e=%b want %b %h %b",
                 n, b1.rd_valid, b1.rd_data, b1.err, ev, exp1, ee);
      end
    end
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid_clear;
    int cnt;
    idle_all();
    rst_n = 0;
    tick();
    rst_n = 1;
    repeat (10) tick();
    rst_n = 0;
    #1;
    n_chk++;
    if (b0.busy !== 1'b1 || b0.rd_valid !== 1'b0 || b1.rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset got busy=%b v=%b d1=%h want 1 0 0",
               b0.busy, b0.rd_valid, b1.rd_data);
    end
    tick();
    rst_n = 1;
    cnt = 0;
    while (cnt < 100) begin
      tick();
      cnt++;
      if (b0.busy !== 1'b1) break;
    end
    n_chk++;
    if (cnt != D0) begin
      n_fail++; $display("FAIL mid_clear_edges got %0d want %0d", cnt, D0);
    end
    for (int a = 0; a < D0; a++) begin
      b0.rd_en = 1; b0.rd_addr = 5'(a);
      tick();
      n_chk++;
      if (b0.rd_data !== 32'h0 || b0.rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reclear[%0d] got %h v=%b want 0 1",
                 a, b0.rd_data, b0.rd_valid);
      end
    end
    b0.rd_en = 0;
    for (int a = 0; a < D1; a++) begin
      b1.rd_en = 1; b1.rd_addr = 5'(a);
      tick();
      n_chk++;
      if (b1.rd_data !== m1[a] || b1.rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL survive[%0d] got %h v=%b want %h 1",
                 a, b1.rd_data, b1.rd_valid, m1[a]);
      end
    end
    idle_all();
    tick();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_clear_readback();
    test_byte_enable();
    test_forwarding();
    test_random_d0();
    test_fill_d1();
    test_out_of_range();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
